// File: rtl/syn_fifo_param_if.sv
// Producer/consumer handshake bundle for syn_fifo_param: write/read requests,
// flush, registered read data and occupancy/status flags.
`timescale 1ns/1ps
interface syn_fifo_param_if #(
    parameter int WIDTH   = 128,
    parameter int ADDRESS = 10
);
    logic               clr;
    logic               wr;
    logic [WIDTH-1:0]   data_in;
    logic               rd;
    logic [WIDTH-1:0]   data_out;
    logic               rd_valid;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [ADDRESS:0]   count;
    logic               overflow;
    logic               underflow;

    modport master (
        output clr, wr, data_in, rd,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr, data_in, rd,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/syn_fifo_param.sv
// Parametrised single-clock FIFO with full-depth occupancy, count, almost flags
// and registered read. Define SYN_FIFO_ERR_EN for sticky overflow/underflow flags.
`timescale 1ns/1ps
module syn_fifo_param #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 1024,
    parameter int ADDRESS  = 10,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              reset,
    syn_fifo_param_if.slave   bus
);
    localparam logic [ADDRESS:0]   DEPTH_CNT = (ADDRESS+1)'(DEPTH);
    localparam logic [ADDRESS:0]   AF_CNT    = (ADDRESS+1)'(AF_LEVEL);
    localparam logic [ADDRESS:0]   AE_CNT    = (ADDRESS+1)'(AE_LEVEL);
    localparam logic [ADDRESS:0]   CNT_ONE   = (ADDRESS+1)'(1);
    localparam logic [ADDRESS-1:0] PTR_ONE   = ADDRESS'(1);

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [ADDRESS-1:0] wr_ptr_r;
    logic [ADDRESS-1:0] rd_ptr_r;
    logic [ADDRESS:0]   count_r;
    logic [WIDTH-1:0]   data_out_r;
    logic               rd_valid_r;
    logic               full_r;
    logic               empty_r;
    logic               almost_full_r;
    logic               almost_empty_r;
    logic               overflow_r;
    logic               underflow_r;

    logic               wa_s;
    logic               ra_s;
    logic [ADDRESS:0]   count_nxt_s;
    logic               ovf_set_s;
    logic               udf_set_s;

    // Accept decisions and next occupancy; a read frees the slot a write at full needs.
    always_comb begin
        wa_s        = 1'b0;
        ra_s        = 1'b0;
        count_nxt_s = count_r;
        if (bus.clr) begin
            wa_s        = 1'b0;
            ra_s        = 1'b0;
            count_nxt_s = '0;
        end else begin
            ra_s = bus.rd & ~empty_r;
            wa_s = bus.wr & (~full_r | ra_s);
            case ({wa_s, ra_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Error-event detection; flushed cycles never count as errors.
    always_comb begin
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
`ifdef SYN_FIFO_ERR_EN
        if (bus.clr) begin
            ovf_set_s = 1'b0;
            udf_set_s = 1'b0;
        end else begin
            ovf_set_s = bus.wr & full_r & ~bus.rd;
            udf_set_s = bus.rd & empty_r;
        end
`else
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
`endif
    end

    // Storage array; deliberately unreset.
    always_ff @(posedge clk) begin
        if (wa_s) begin
            mem_r[wr_ptr_r] <= bus.data_in;
        end
    end

    // Pointers, occupancy and status flags; flags track the next count so they
    // always describe the state after the most recent edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            if (bus.clr) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (wa_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (ra_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
            count_r        <= count_nxt_s;
            full_r         <= (count_nxt_s == DEPTH_CNT);
            empty_r        <= (count_nxt_s == '0);
            almost_full_r  <= (count_nxt_s >= AF_CNT);
            almost_empty_r <= (count_nxt_s <= AE_CNT);
        end
    end

    // Registered read port; data_out holds when no read is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_r <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= ra_s;
            if (ra_s) begin
                data_out_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.clr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end
            if (udf_set_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.rd_valid     = rd_valid_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_syn_fifo_param.sv
// Directed bench for syn_fifo_param at WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=2.
`timescale 1ns/1ps
module tb_syn_fifo_param;
    localparam int W = 8;
`ifdef SYN_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    typedef struct {
        logic       clr;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [4:0] count;
        logic       empty;
        logic       full;
        logic       af;
        logic       ae;
        logic       valid;
        logic [7:0] dout;
        logic       ovf;
        logic       udf;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];

    syn_fifo_param_if #(.WIDTH(W), .ADDRESS(4)) fifo_bus ();

    syn_fifo_param #(
        .WIDTH(W), .DEPTH(16), .ADDRESS(4), .AF_LEVEL(12), .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(fifo_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected flags come from the occupancy using the bench's own thresholds.
    function automatic vec_t mk(logic clr, logic wr, logic rd, logic [7:0] din,
                                logic [4:0] cnt, logic valid, logic [7:0] dout,
                                logic ovf, logic udf);
        vec_t v;
        v.clr = clr; v.wr = wr; v.rd = rd; v.din = din;
        v.count = cnt;
        v.empty = (cnt == 5'd0);
        v.full  = (cnt == 5'd16);
        v.af    = (cnt >= 5'd12);
        v.ae    = (cnt <= 5'd2);
        v.valid = valid; v.dout = dout; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", tag, field, act, exp);
        end
    endtask

    task automatic check_now(input string tag, input vec_t e);
        chk(tag, "count",        32'(fifo_bus.count),        32'(e.count));
        chk(tag, "empty",        32'(fifo_bus.empty),        32'(e.empty));
        chk(tag, "full",         32'(fifo_bus.full),         32'(e.full));
        chk(tag, "almost_full",  32'(fifo_bus.almost_full),  32'(e.af));
        chk(tag, "almost_empty", 32'(fifo_bus.almost_empty), 32'(e.ae));
        chk(tag, "rd_valid",     32'(fifo_bus.rd_valid),     32'(e.valid));
        chk(tag, "data_out",     32'(fifo_bus.data_out),     32'(e.dout));
        chk(tag, "overflow",     32'(fifo_bus.overflow),     32'(e.ovf));
        chk(tag, "underflow",    32'(fifo_bus.underflow),    32'(e.udf));
    endtask

    // Drive one cycle of inputs, let the edge happen, then check 1 ns later.
    task automatic apply(input string tag, input vec_t v);
        fifo_bus.clr     = v.clr;
        fifo_bus.wr      = v.wr;
        fifo_bus.rd      = v.rd;
        fifo_bus.data_in = v.din;
        @(posedge clk);
        #1;
        check_now(tag, v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        fifo_bus.clr = 1'b0; fifo_bus.wr = 1'b0; fifo_bus.rd = 1'b0;
        fifo_bus.data_in = '0;

        // Table: fill with 0..15, overflow attempt, drain, underflow attempt.
        for (int k = 1; k <= 16; k++)
            vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'(k-1), 5'(k), 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hAA, 5'd16, 1'b0, 8'h00, ERR, 1'b0));
        for (int j = 0; j < 16; j++)
            vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 5'(15-j), 1'b1, 8'(j), ERR, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 8'd15, ERR, ERR));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd15, ERR, ERR));

        #12;
        check_now("reset_init", mk(1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0));
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Sustained wr&rd at count=3 across pointer wraps.
        apply("clr_a", mk(1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd15, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            apply("prefill3", mk(1'b0, 1'b1, 1'b0, 8'(100+i), 5'(i+1), 1'b0, 8'd15, 1'b0, 1'b0));
        for (int i = 0; i < 40; i++)
            apply($sformatf("stream%0d", i),
                  mk(1'b0, 1'b1, 1'b1, 8'(103+i), 5'd3, 1'b1, 8'(100+i), 1'b0, 1'b0));

        // wr&rd at empty: write taken, read refused.
        apply("clr_b", mk(1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd139, 1'b0, 1'b0));
        apply("wrrd_empty", mk(1'b0, 1'b1, 1'b1, 8'd50, 5'd1, 1'b0, 8'd139, 1'b0, ERR));

        // wr&rd at full: oldest word out, count stays 16, no overflow.
        for (int i = 0; i < 15; i++)
            apply("fill_b", mk(1'b0, 1'b1, 1'b0, 8'(51+i), 5'(i+2), 1'b0, 8'd139, 1'b0, ERR));
        apply("wrrd_full", mk(1'b0, 1'b1, 1'b1, 8'd66, 5'd16, 1'b1, 8'd50, 1'b0, ERR));
        apply("rd_after_full", mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd15, 1'b1, 8'd51, 1'b0, ERR));

        // Flush at count=9 with wr&rd asserted.
        apply("clr_c", mk(1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd51, 1'b0, 1'b0));
        for (int i = 0; i < 9; i++)
            apply("fill9", mk(1'b0, 1'b1, 1'b0, 8'(200+i), 5'(i+1), 1'b0, 8'd51, 1'b0, 1'b0));
        apply("clr_wrrd", mk(1'b1, 1'b1, 1'b1, 8'd77, 5'd0, 1'b0, 8'd51, 1'b0, 1'b0));
        apply("post_clr_wr", mk(1'b0, 1'b1, 1'b0, 8'hC3, 5'd1, 1'b0, 8'd51, 1'b0, 1'b0));
        apply("post_clr_rd", mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'hC3, 1'b0, 1'b0));

        // Asynchronous reset mid-cycle with count=5 and a read in flight.
        for (int i = 0; i < 6; i++)
            apply("fill6", mk(1'b0, 1'b1, 1'b0, 8'(i+1), 5'(i+1), 1'b0, 8'hC3, 1'b0, 1'b0));
        apply("rd_to5", mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd5, 1'b1, 8'd1, 1'b0, 1'b0));
        fifo_bus.rd = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_now("async_reset", mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_now("reset_held", mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0));
        fifo_bus.rd = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        apply("post_rst_wr", mk(1'b0, 1'b1, 1'b0, 8'h5A, 5'd1, 1'b0, 8'h00, 1'b0, 1'b0));
        apply("post_rst_rd", mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'h5A, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
